// File: rtl/serial_word_comparator_pkg.sv
// Shared types and sizing helpers for the serial word comparator.
// FSM encoding, slice-count derivation and slice-index width.
package serial_word_comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int nslice_of(input int width);
        return width / 2;
    endfunction

    // Index width is clog2 of the slice count, never narrower than one bit.
    function automatic int idx_width(input int nslice);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < nslice) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/comparator_2bit.sv
// Combinational 2-bit unsigned magnitude compare cell.
// Exactly one of eq/gt/lt is high for any input pair.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    // Direct magnitude compare of the two-bit slice.
    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/serial_word_comparator.sv
// Multi-cycle WIDTH-bit unsigned comparator walking two bits per clock,
// MSB slice first, with early exit on the first differing slice.
module serial_word_comparator
    import serial_word_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NSLICE = nslice_of(WIDTH);
    localparam int IDX_W  = idx_width(NSLICE);
    localparam int SEL_W  = IDX_W + 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   ra_r;
    logic [WIDTH-1:0]   rb_r;
    logic [WIDTH-1:0]   ra_nxt_s;
    logic [WIDTH-1:0]   rb_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic               eq_r;
    logic               gt_r;
    logic               lt_r;
    logic               eq_nxt_s;
    logic               gt_nxt_s;
    logic               lt_nxt_s;
    logic [SEL_W-1:0]   bit_sel_s;
    logic [1:0]         slice_a_s;
    logic [1:0]         slice_b_s;
    logic               cell_eq_s;
    logic               cell_gt_s;
    logic               cell_lt_s;
    logic               last_slice_s;

    // Select the current two-bit slice of each latched operand.
    always_comb begin
        bit_sel_s    = {idx_r, 1'b0};
        slice_a_s    = ra_r[bit_sel_s +: 2];
        slice_b_s    = rb_r[bit_sel_s +: 2];
        last_slice_s = (idx_r == {IDX_W{1'b0}});
    end

    comparator_2bit u_cell (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .eq (cell_eq_s),
        .gt (cell_gt_s),
        .lt (cell_lt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave RUN on a differing slice or after the LSB slice.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!cell_eq_s || last_slice_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output and datapath next values; results hold unless a comparison completes.
    always_comb begin
        ra_nxt_s   = ra_r;
        rb_nxt_s   = rb_r;
        idx_nxt_s  = idx_r;
        busy_nxt_s = busy_r;
        done_nxt_s = 1'b0;
        eq_nxt_s   = eq_r;
        gt_nxt_s   = gt_r;
        lt_nxt_s   = lt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    ra_nxt_s   = a;
                    rb_nxt_s   = b;
                    idx_nxt_s  = IDX_W'(NSLICE - 1);
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (!cell_eq_s) begin
                    eq_nxt_s   = 1'b0;
                    gt_nxt_s   = cell_gt_s;
                    lt_nxt_s   = cell_lt_s;
                    done_nxt_s = 1'b1;
                    busy_nxt_s = 1'b0;
                end else if (last_slice_s) begin
                    eq_nxt_s   = 1'b1;
                    gt_nxt_s   = 1'b0;
                    lt_nxt_s   = 1'b0;
                    done_nxt_s = 1'b1;
                    busy_nxt_s = 1'b0;
                end else begin
                    idx_nxt_s  = idx_r - IDX_W'(1);
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_r   <= {WIDTH{1'b0}};
            rb_r   <= {WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            eq_r   <= 1'b0;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
        end else begin
            ra_r   <= ra_nxt_s;
            rb_r   <= rb_nxt_s;
            idx_r  <= idx_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            eq_r   <= eq_nxt_s;
            gt_r   <= gt_nxt_s;
            lt_r   <= lt_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign eq   = eq_r;
    assign gt   = gt_r;
    assign lt   = lt_r;

endmodule
